// File: rtl/axi_trace_arbiter.sv
// axi_trace_arbiter: passive AXI4 handshake tracer. It timestamps AW/W/B/AR/R
// handshakes, queues them in per-channel FIFOs, and drains them round-robin into
// one valid/ready record stream with drop accounting.
// Optional macro AXI_TRACE_DATA_EN: keeps WDATA/RDATA/WSTRB in the records.
// Without it, rec_data and rec_strb are tied to 0.
module axi_trace_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  input  logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  input  logic                    RREADY,
  input  logic                    cap_en,
  input  logic                    clr_stat,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [2:0]              rec_chan,
  output logic [63:0]             rec_cycle,
  output logic [ID_WIDTH-1:0]     rec_id,
  output logic [ADDR_WIDTH-1:0]   rec_addr,
  output logic [DATA_WIDTH-1:0]   rec_data,
  output logic [DATA_WIDTH/8-1:0] rec_strb,
  output logic [15:0]             rec_info,
  output logic [15:0]             drop_cnt,
  output logic [4:0]              ovf,
  output logic                    busy
);

  localparam int unsigned NCH    = 5;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned REC_W  = 64 + ID_WIDTH + ADDR_WIDTH + 16;

  logic [63:0]       cyc_q;
  logic [2:0]        rr_q;
  logic [PTR_W-1:0]  wptr_q [NCH];
  logic [PTR_W-1:0]  rptr_q [NCH];
  logic [CNT_W-1:0]  cnt_q  [NCH];
  logic [REC_W-1:0]  mem_q  [NCH][FIFO_DEPTH];
  logic [REC_W-1:0]  rec_in_c [NCH];
  logic [REC_W-1:0]  head_c;

  logic [NCH-1:0]    push_c, accept_c, drop_c, pop_c, full_c, empty_c;
  logic              take_c, gnt_any_c;
  logic [2:0]        gnt_idx_c;
  logic [3:0]        arb_idx_c;
  logic [2:0]        ndrop_c;
  logic [16:0]       drop_sum_c;

  logic              rec_valid_q;
  logic [2:0]        rec_chan_q;
  logic [63:0]       rec_cycle_q;
  logic [ID_WIDTH-1:0]   rec_id_q;
  logic [ADDR_WIDTH-1:0] rec_addr_q;
  logic [15:0]       rec_info_q;
  logic [15:0]       drop_q;
  logic [4:0]        ovf_q;

  // Handshakes that are captured this cycle, one bit per channel code
  assign push_c = {RVALID & RREADY, ARVALID & ARREADY, BVALID & BREADY,
                   WVALID & WREADY, AWVALID & AWREADY} & {NCH{cap_en}};

  // Record images: {cycle, id, addr, info}
  assign rec_in_c[0] = {cyc_q, AWID, AWADDR, 3'b000, AWBURST, AWSIZE, AWLEN};
  assign rec_in_c[1] = {cyc_q, {ID_WIDTH{1'b0}}, {ADDR_WIDTH{1'b0}}, WLAST, 15'd0};
  assign rec_in_c[2] = {cyc_q, BID, {ADDR_WIDTH{1'b0}}, 1'b0, BRESP, 13'd0};
  assign rec_in_c[3] = {cyc_q, ARID, ARADDR, 3'b000, ARBURST, ARSIZE, ARLEN};
  assign rec_in_c[4] = {cyc_q, RID, {ADDR_WIDTH{1'b0}}, RLAST, RRESP, 13'd0};

  // FIFO status flags
  always_comb begin
    full_c  = '0;
    empty_c = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      full_c[k]  = (cnt_q[k] == CNT_W'(FIFO_DEPTH));
      empty_c[k] = (cnt_q[k] == '0);
    end
  end

  // Round-robin search from rr_q over non-empty FIFOs
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    arb_idx_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      arb_idx_c = {1'b0, rr_q} + 4'(i);
      if (arb_idx_c >= 4'(NCH)) arb_idx_c = arb_idx_c - 4'(NCH);
      if (!gnt_any_c && !empty_c[arb_idx_c[2:0]]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = arb_idx_c[2:0];
      end
    end
  end

  assign take_c   = !rec_valid_q || rec_ready;
  assign pop_c    = (take_c && gnt_any_c) ? (5'b00001 << gnt_idx_c) : 5'b00000;
  // A full FIFO being popped this cycle still has room for the push
  assign accept_c = push_c & (~full_c | pop_c);
  assign drop_c   = push_c & full_c & ~pop_c;
  assign head_c   = mem_q[gnt_idx_c][rptr_q[gnt_idx_c]];

  // Simultaneous drop count and saturating accumulate
  always_comb begin
    ndrop_c = '0;
    for (int unsigned k = 0; k < NCH; k++) ndrop_c = ndrop_c + 3'(drop_c[k]);
    drop_sum_c = {1'b0, drop_q} + 17'(ndrop_c);
  end

  // Free-running timestamp and round-robin pointer
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cyc_q <= '0;
      rr_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      if (pop_c != '0) rr_q <= (gnt_idx_c == 3'd4) ? 3'd0 : gnt_idx_c + 3'd1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (accept_c[k]) wptr_q[k] <= wptr_q[k] + PTR_W'(1);
        if (pop_c[k])    rptr_q[k] <= rptr_q[k] + PTR_W'(1);
        if (accept_c[k] && !pop_c[k])      cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        else if (!accept_c[k] && pop_c[k]) cnt_q[k] <= cnt_q[k] - CNT_W'(1);
      end
    end
  end

  // FIFO storage, no reset needed since occupancy gates reads
  always_ff @(posedge ACLK) begin
    for (int unsigned k = 0; k < NCH; k++)
      if (accept_c[k]) mem_q[k][wptr_q[k]] <= rec_in_c[k];
  end

  // Output record register, loaded on every grant
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rec_valid_q <= 1'b0;
      rec_chan_q  <= '0;
      rec_cycle_q <= '0;
      rec_id_q    <= '0;
      rec_addr_q  <= '0;
      rec_info_q  <= '0;
    end else if (take_c) begin
      rec_valid_q <= gnt_any_c;
      if (gnt_any_c) begin
        rec_chan_q  <= gnt_idx_c;
        rec_cycle_q <= head_c[REC_W-1 -: 64];
        rec_id_q    <= head_c[ADDR_WIDTH+16+ID_WIDTH-1 -: ID_WIDTH];
        rec_addr_q  <= head_c[ADDR_WIDTH+16-1 -: ADDR_WIDTH];
        rec_info_q  <= head_c[15:0];
      end
    end
  end

  // Drop statistics; clear wins over same-cycle drops
  always_ff @(posedge ACLK) begin
    if (ARESET || clr_stat) begin
      drop_q <= '0;
      ovf_q  <= '0;
    end else begin
      drop_q <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
      ovf_q  <= ovf_q | drop_c;
    end
  end

`ifdef AXI_TRACE_DATA_EN
  localparam int unsigned PAY_W = DATA_WIDTH + STRB_W;
  logic [PAY_W-1:0]      pay_in_c [NCH];
  logic [PAY_W-1:0]      pmem_q   [NCH][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rec_data_q;
  logic [STRB_W-1:0]     rec_strb_q;

  assign pay_in_c[0] = '0;
  assign pay_in_c[1] = {WDATA, WSTRB};
  assign pay_in_c[2] = '0;
  assign pay_in_c[3] = '0;
  assign pay_in_c[4] = {RDATA, {STRB_W{1'b0}}};

  // Payload storage alongside the record FIFOs
  always_ff @(posedge ACLK) begin
    for (int unsigned k = 0; k < NCH; k++)
      if (accept_c[k]) pmem_q[k][wptr_q[k]] <= pay_in_c[k];
  end

  // Payload half of the output register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rec_data_q <= '0;
      rec_strb_q <= '0;
    end else if (take_c && gnt_any_c) begin
      {rec_data_q, rec_strb_q} <= pmem_q[gnt_idx_c][rptr_q[gnt_idx_c]];
    end
  end

  assign rec_data = rec_data_q;
  assign rec_strb = rec_strb_q;
`else
  logic unused_data;
  assign unused_data = ^{WDATA, WSTRB, RDATA};
  assign rec_data    = '0;
  assign rec_strb    = '0;
`endif

  assign rec_valid = rec_valid_q;
  assign rec_chan  = rec_chan_q;
  assign rec_cycle = rec_cycle_q;
  assign rec_id    = rec_id_q;
  assign rec_addr  = rec_addr_q;
  assign rec_info  = rec_info_q;
  assign drop_cnt  = drop_q;
  assign ovf       = ovf_q;
  assign busy      = (~empty_c != '0) || rec_valid_q;

endmodule

// File: tb/tb_axi_trace_arbiter.sv
// Bench for axi_trace_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_axi_trace_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID, BID, ARID, RID, WSTRB, rec_strb, rec_id;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, rec_addr, rec_data;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, rec_chan;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic        cap_en, clr_stat, rec_valid, rec_ready, busy;
  logic [63:0] rec_cycle;
  logic [15:0] rec_info, drop_cnt;
  logic [4:0]  ovf;

  int checks = 0;
  int errors = 0;

  axi_trace_arbiter dut (
    .ACLK(clk), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .cap_en(cap_en), .clr_stat(clr_stat),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_chan(rec_chan), .rec_cycle(rec_cycle),
    .rec_id(rec_id), .rec_addr(rec_addr), .rec_data(rec_data), .rec_strb(rec_strb),
    .rec_info(rec_info), .drop_cnt(drop_cnt), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  chan;
    logic [63:0] cyc;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [15:0] info;
  } rec_t;

  rec_t            mq [5][$];
  rec_t            m_out;
  bit              m_ov = 1'b0;
  bit              m_on = 1'b0;
  int              m_rr = 0;
  int              m_drop = 0;
  logic [4:0]      m_ovf = '0;
  longint unsigned m_cyc = 0;

  function automatic rec_t mk(int k);
    rec_t r;
    r.chan = 3'(k); r.cyc = m_cyc; r.id = '0; r.addr = '0; r.data = '0; r.strb = '0; r.info = '0;
    case (k)
      0: begin r.id = AWID; r.addr = AWADDR; r.info = {3'b000, AWBURST, AWSIZE, AWLEN}; end
      1: begin r.data = WDATA; r.strb = WSTRB; r.info = {WLAST, 15'd0}; end
      2: begin r.id = BID; r.info = {1'b0, BRESP, 13'd0}; end
      3: begin r.id = ARID; r.addr = ARADDR; r.info = {3'b000, ARBURST, ARSIZE, ARLEN}; end
      default: begin r.id = RID; r.data = RDATA; r.info = {RLAST, RRESP, 13'd0}; end
    endcase
    return r;
  endfunction

  task model_step;
    logic [4:0] hs;
    rec_t nr [5];
    bit   take, found;
    int   w, nd, c;
    hs = {RVALID & RREADY, ARVALID & ARREADY, BVALID & BREADY, WVALID & WREADY,
          AWVALID & AWREADY} & {5{cap_en}};
    for (int k = 0; k < 5; k++) nr[k] = mk(k);
    take = !m_ov || rec_ready;
    found = 1'b0; w = 0;
    for (int i = 0; i < 5; i++) begin
      c = (m_rr + i) % 5;
      if (!found && mq[c].size() > 0) begin found = 1'b1; w = c; end
    end
    if (take) begin
      if (found) begin
        m_out = mq[w].pop_front();
        m_ov  = 1'b1;
        m_rr  = (w + 1) % 5;
      end else m_ov = 1'b0;
    end
    nd = 0;
    for (int k = 0; k < 5; k++)
      if (hs[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(nr[k]);
        else begin nd++; m_ovf[k] = 1'b1; end
      end
    if (clr_stat) begin m_drop = 0; m_ovf = '0; end
    else m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
    m_cyc++;
  endtask

  task compare;
    bit   exp_busy;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    exp_busy = m_ov;
    for (int k = 0; k < 5; k++) if (mq[k].size() > 0) exp_busy = 1'b1;
    chk("m.rec_valid", 64'(rec_valid), 64'(m_ov));
    if (m_ov) begin
`ifdef AXI_TRACE_DATA_EN
      exp_data = m_out.data; exp_strb = m_out.strb;
`else
      exp_data = '0; exp_strb = '0;
`endif
      chk("m.rec_chan",  64'(rec_chan),  64'(m_out.chan));
      chk("m.rec_cycle", rec_cycle,      m_out.cyc);
      chk("m.rec_id",    64'(rec_id),    64'(m_out.id));
      chk("m.rec_addr",  64'(rec_addr),  64'(m_out.addr));
      chk("m.rec_info",  64'(rec_info),  64'(m_out.info));
      chk("m.rec_data",  64'(rec_data),  64'(exp_data));
      chk("m.rec_strb",  64'(rec_strb),  64'(exp_strb));
    end
    chk("m.drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("m.ovf",      64'(ovf),      64'(m_ovf));
    chk("m.busy",     64'(busy),     64'(exp_busy));
  endtask

  // Model advances on each edge; outputs compared just after it
  always @(posedge clk) begin
    if (ARESET) begin
      for (int k = 0; k < 5; k++) mq[k].delete();
      m_ov = 1'b0; m_rr = 0; m_drop = 0; m_ovf = '0; m_cyc = 0; m_on = 1'b1;
    end else if (m_on) begin
      model_step();
    end
    #1;
    if (m_on) compare();
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] v, input logic [4:0] r, input int t);
    AWVALID = v[0]; AWREADY = r[0]; AWID = 4'(t); AWADDR = 32'h1000 + 32'(t << 4);
    AWLEN = 8'(t); AWSIZE = 3'(t); AWBURST = 2'(t);
    WVALID = v[1]; WREADY = r[1]; WDATA = 32'hA000_0000 + 32'(t); WSTRB = 4'(t + 1);
    WLAST = (t % 2 == 1);
    BVALID = v[2]; BREADY = r[2]; BID = 4'(t + 2); BRESP = 2'(t + 1);
    ARVALID = v[3]; ARREADY = r[3]; ARID = 4'(t); ARADDR = 32'h8000 + 32'(t << 2);
    ARLEN = 8'(t + 3); ARSIZE = 3'(t + 1); ARBURST = 2'(t + 2);
    RVALID = v[4]; RREADY = r[4]; RID = 4'(t + 5); RDATA = 32'hB000_0000 + 32'(t);
    RRESP = 2'(t); RLAST = (t % 3 == 0);
  endtask

  // Leaves the bench mid-way through post-reset cycle 0
  task automatic do_reset();
    @(negedge clk); ARESET = 1'b1;
    @(negedge clk); ARESET = 1'b0;
  endtask

  task automatic burst5(input int t);
    drive(5'h1F, 5'h1F, t);
    @(negedge clk); drive(5'h00, 5'h00, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rr.valid", 64'(rec_valid), 64'd1);
      chk("rr.chan",  64'(rec_chan),  64'(i));
      @(negedge clk);
    end
    chk("rr.idle", 64'(rec_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b0; cap_en = 1'b1; clr_stat = 1'b0; rec_ready = 1'b1;
    drive(5'h00, 5'h00, 0);

    // Reset state
    do_reset();
    chk("rst.rec_valid", 64'(rec_valid), 64'd0);
    chk("rst.rec_cycle", rec_cycle,      64'd0);
    chk("rst.rec_addr",  64'(rec_addr),  64'd0);
    chk("rst.rec_info",  64'(rec_info),  64'd0);
    chk("rst.drop_cnt",  64'(drop_cnt),  64'd0);
    chk("rst.ovf",       64'(ovf),       64'd0);
    chk("rst.busy",      64'(busy),      64'd0);

    // Single AW handshake at counter 10
    do_reset();
    repeat (10) @(negedge clk);
    drive(5'h01, 5'h01, 0);
    AWID = 4'd3; AWADDR = 32'h1000; AWLEN = 8'd7; AWSIZE = 3'd2; AWBURST = 2'd1;
    @(negedge clk); drive(5'h00, 5'h00, 0);
    chk("aw.c11_valid", 64'(rec_valid), 64'd0);
    @(negedge clk);
    chk("aw.valid", 64'(rec_valid), 64'd1);
    chk("aw.chan",  64'(rec_chan),  64'd0);
    chk("aw.cycle", rec_cycle,      64'd10);
    chk("aw.id",    64'(rec_id),    64'd3);
    chk("aw.addr",  64'(rec_addr),  64'h1000);
    chk("aw.info",  64'(rec_info),  64'h0A07);

    // Five simultaneous channels, twice
    do_reset();
    burst5(5);
    burst5(9);

    // Overflow of the W FIFO with the sink stalled
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(5'h02, 5'h02, i);
      @(negedge clk);
    end
    drive(5'h00, 5'h00, 0);
    chk("ovf.drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf.ovf",      64'(ovf),      64'b00010);
    for (int i = 0; i < 5; i++) begin
      chk("ovf.w_valid", 64'(rec_valid), 64'd1);
      chk("ovf.w_chan",  64'(rec_chan),  64'd1);
      chk("ovf.w_cycle", rec_cycle,      64'(i));
`ifdef AXI_TRACE_DATA_EN
      chk("ovf.w_data", 64'(rec_data), 64'(32'hA000_0000 + 32'(i)));
`endif
      if (i == 0) rec_ready = 1'b1;
      @(negedge clk);
    end
    chk("ovf.drained", 64'(rec_valid), 64'd0);
    chk("ovf.idle",    64'(busy),      64'd0);

    // Capture disabled
    cap_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'h10, 5'h10, i);
      @(negedge clk);
    end
    drive(5'h00, 5'h00, 0);
    repeat (3) @(negedge clk);
    chk("cap.valid",    64'(rec_valid), 64'd0);
    chk("cap.busy",     64'(busy),      64'd0);
    chk("cap.drop_cnt", 64'(drop_cnt),  64'd1);
    cap_en = 1'b1;

    // Clear in the same cycle as a drop
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(5'h02, 5'h02, i);
      if (i == 5) begin
        chk("clr.pre_drop", 64'(drop_cnt), 64'd1);
        clr_stat = 1'b1;
      end
      @(negedge clk);
    end
    clr_stat = 1'b0;
    drive(5'h00, 5'h00, 0);
    chk("clr.drop_cnt", 64'(drop_cnt), 64'd0);
    chk("clr.ovf",      64'(ovf),      64'd0);
    rec_ready = 1'b1;
    repeat (7) @(negedge clk);

    // Reset with records queued
    rec_ready = 1'b0;
    drive(5'h07, 5'h07, 3);
    @(negedge clk); drive(5'h00, 5'h00, 0);
    @(negedge clk);
    chk("rst2.busy_before", 64'(busy), 64'd1);
    ARESET = 1'b1;
    @(negedge clk); ARESET = 1'b0;
    chk("rst2.valid", 64'(rec_valid), 64'd0);
    chk("rst2.busy",  64'(busy),      64'd0);
    rec_ready = 1'b1;
    drive(5'h08, 5'h08, 6);
    @(negedge clk); drive(5'h00, 5'h00, 0);
    @(negedge clk);
    chk("rst2.ar_valid", 64'(rec_valid), 64'd1);
    chk("rst2.ar_chan",  64'(rec_chan),  64'd3);
    chk("rst2.ar_cycle", rec_cycle,      64'd0);
    chk("rst2.ar_id",    64'(rec_id),    64'd6);

    // Mixed valid/ready patterns with a throttled sink
    for (int i = 0; i < 60; i++) begin
      drive(5'(i * 7 + 3), 5'(i * 11 + 5), i);
      rec_ready = (i % 3 != 0);
      @(negedge clk);
    end
    drive(5'h00, 5'h00, 0);
    rec_ready = 1'b1;
    repeat (25) @(negedge clk);
    chk("mix.idle", 64'(busy), 64'd0);

    // Drop counter saturation
    rec_ready = 1'b0;
    for (int i = 0; i < 14000; i++) begin
      drive(5'h1F, (i % 7 == 0) ? 5'h0F : 5'h1F, i);
      @(negedge clk);
    end
    drive(5'h00, 5'h00, 0);
    @(negedge clk);
    chk("sat.drop_cnt", 64'(drop_cnt), 64'hFFFF);
    chk("sat.ovf",      64'(ovf),      64'h1F);
    clr_stat = 1'b1;
    @(negedge clk); clr_stat = 1'b0;
    chk("sat.cleared", 64'(drop_cnt), 64'd0);
    rec_ready = 1'b1;
    repeat (25) @(negedge clk);
    chk("sat.idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
